// File: rtl/alu_regfile_pipe.sv
// Two-stage register-file + ALU execute datapath: operand latch, then registered result with write-back.
// Optional same-edge read forwarding is enabled by defining RF_BYPASS_EN.
module alu_regfile_pipe #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] Read1,
    input  logic [ADDR_W-1:0] Read2,
    input  logic [1:0]        ALUOp,
    input  logic [3:0]        FuncCode,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALUOut,
    output logic              Zero,
    output logic              ovf
);

    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int SH_W     = $clog2(DATA_W);

    // Handshake: in_valid is a one-cycle issue strobe with no ready; the pipe never
    // stalls, and out_valid pulses exactly one cycle per issued op, two edges later.

    typedef enum logic [3:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SLL, OP_SRL, OP_PASSB, OP_NONE
    } op_e;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              s1_valid;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    op_e               s1_op;
    logic              s1_wb_en;
    logic [ADDR_W-1:0] s1_dest;

    op_e               dec_op;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              wb_fire;
    logic              ext_fire;

    assign wb_fire  = s1_valid && s1_wb_en && !(ZERO_REG != 0 && s1_dest == '0);
    assign ext_fire = RegWrite && !(ZERO_REG != 0 && WriteReg == '0);

    always_comb begin
        dec_op = OP_NONE;
        case (ALUOp)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b11: dec_op = OP_PASSB;
            default: begin
                case (FuncCode)
                    4'b0000: dec_op = OP_ADD;
                    4'b0010: dec_op = OP_SUB;
                    4'b0100: dec_op = OP_AND;
                    4'b0101: dec_op = OP_OR;
                    4'b0110: dec_op = OP_XOR;
                    4'b0111: dec_op = OP_NOR;
                    4'b1010: dec_op = OP_SLT;
                    4'b1011: dec_op = OP_SLTU;
                    4'b1000: dec_op = OP_SLL;
                    4'b1001: dec_op = OP_SRL;
                    default: dec_op = OP_NONE;
                endcase
            end
        endcase
    end

    // Later assignment wins, so write-back takes priority over the external write.
    always_comb begin
        rd_a = regs[Read1];
`ifdef RF_BYPASS_EN
        if (ext_fire && WriteReg == Read1) rd_a = WriteData;
        if (wb_fire && s1_dest == Read1) rd_a = alu_res;
`endif
        if (ZERO_REG != 0 && Read1 == '0) rd_a = '0;
    end

    always_comb begin
        rd_b = regs[Read2];
`ifdef RF_BYPASS_EN
        if (ext_fire && WriteReg == Read2) rd_b = WriteData;
        if (wb_fire && s1_dest == Read2) rd_b = alu_res;
`endif
        if (ZERO_REG != 0 && Read2 == '0) rd_b = '0;
    end

    assign sum  = s1_a + s1_b;
    assign diff = s1_a - s1_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (s1_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) && (sum[DATA_W-1] != s1_a[DATA_W-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) && (diff[DATA_W-1] != s1_a[DATA_W-1]);
            end
            OP_AND:   alu_res = s1_a & s1_b;
            OP_OR:    alu_res = s1_a | s1_b;
            OP_XOR:   alu_res = s1_a ^ s1_b;
            OP_NOR:   alu_res = ~(s1_a | s1_b);
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, ($signed(s1_a) < $signed(s1_b))};
            OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, (s1_a < s1_b)};
            OP_SLL:   alu_res = s1_a << s1_b[SH_W-1:0];
            OP_SRL:   alu_res = s1_a >> s1_b[SH_W-1:0];
            OP_PASSB: alu_res = s1_b;
            default:  alu_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (ext_fire) regs[WriteReg] <= WriteData;
            if (wb_fire)  regs[s1_dest]  <= alu_res;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= OP_NONE;
            s1_wb_en <= 1'b0;
            s1_dest  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a     <= rd_a;
                s1_b     <= rd_b;
                s1_op    <= dec_op;
                s1_wb_en <= wb_en;
                s1_dest  <= dest_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            ALUOut    <= '0;
            Zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                ALUOut <= alu_res;
                Zero   <= (alu_res == '0);
                ovf    <= alu_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// Self-checking bench for alu_regfile_pipe: reference register-file/ALU model feeding an expected queue.
// Honours RF_BYPASS_EN the same way the design does.
module tb_alu_regfile_pipe;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int EW       = DATA_W + 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [ADDR_W-1:0] Read1 = '0;
    logic [ADDR_W-1:0] Read2 = '0;
    logic [1:0]        ALUOp = '0;
    logic [3:0]        FuncCode = '0;
    logic              wb_en = 1'b0;
    logic [ADDR_W-1:0] dest_addr = '0;
    logic              RegWrite = 1'b0;
    logic [ADDR_W-1:0] WriteReg = '0;
    logic [DATA_W-1:0] WriteData = '0;
    logic              out_valid;
    logic [DATA_W-1:0] ALUOut;
    logic              Zero;
    logic              ovf;

    always #5 clk = ~clk;

    alu_regfile_pipe #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .Read1(Read1), .Read2(Read2), .ALUOp(ALUOp), .FuncCode(FuncCode),
        .wb_en(wb_en), .dest_addr(dest_addr),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
        .out_valid(out_valid), .ALUOut(ALUOut), .Zero(Zero), .ovf(ovf)
    );

    logic [EW-1:0]     exp_q[$];
    string             tag_q[$];
    int                errors = 0;
    int                checks = 0;

    logic [DATA_W-1:0] m_rf [NUM_REGS];
    logic              s1_m = 1'b0;
    logic              ov_m = 1'b0;
    logic              pend_wb = 1'b0;
    logic [ADDR_W-1:0] pend_dest = '0;
    logic [DATA_W-1:0] pend_val = '0;
    logic [EW-1:0]     last_exp = '0;
    logic [EW-1:0]     mon_e;
    string             mon_t;

`ifdef RF_BYPASS_EN
    localparam logic [DATA_W-1:0] DEP_RES = 32'd6;
`else
    localparam logic [DATA_W-1:0] DEP_RES = 32'd20;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input logic [ADDR_W-1:0] a);
        return (a == '0) ? '0 : m_rf[a];
    endfunction

    task automatic model_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        if (a != '0) m_rf[a] = d;
    endtask

    // Returns {ovf, result}; overflow from a sign-extended wide sum.
    function automatic logic [DATA_W:0] ref_alu(input logic [1:0] aop, input logic [3:0] fc,
                                                input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   w;
        logic [DATA_W-1:0] r;
        logic              v;
        logic [3:0]        code;
        r = '0;
        v = 1'b0;
        if (aop == 2'b11) return {1'b0, b};
        code = (aop == 2'b00) ? 4'b0000 : (aop == 2'b01) ? 4'b0010 : fc;
        case (code)
            4'b0000: begin w = {a[DATA_W-1], a} + {b[DATA_W-1], b}; r = w[DATA_W-1:0]; v = w[DATA_W] ^ w[DATA_W-1]; end
            4'b0010: begin w = {a[DATA_W-1], a} - {b[DATA_W-1], b}; r = w[DATA_W-1:0]; v = w[DATA_W] ^ w[DATA_W-1]; end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            4'b0111: r = ~(a | b);
            4'b1010: r = ($signed(a) < $signed(b)) ? 1 : 0;
            4'b1011: r = (a < b) ? 1 : 0;
            4'b1000: r = a << b[4:0];
            4'b1001: r = a >> b[4:0];
            default: r = '0;
        endcase
        return {v, r};
    endfunction

    // Drives one cycle of inputs, advances the reference model across the edge.
    task automatic drive_op(input logic iv, input logic [1:0] aop, input logic [3:0] fc,
                            input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                            input logic wb, input logic [ADDR_W-1:0] dst,
                            input logic we, input logic [ADDR_W-1:0] wr, input logic [DATA_W-1:0] wd,
                            input string tag, input logic use_c,
                            input logic [DATA_W-1:0] c_res, input logic c_ovf);
        logic [DATA_W-1:0] a, b, res;
        logic [DATA_W:0]   ro;
        logic              v;
        in_valid = iv; ALUOp = aop; FuncCode = fc; Read1 = r1; Read2 = r2;
        wb_en = wb; dest_addr = dst; RegWrite = we; WriteReg = wr; WriteData = wd;
`ifdef RF_BYPASS_EN
        if (we) model_write(wr, wd);
        if (pend_wb) model_write(pend_dest, pend_val);
        a = model_read(r1);
        b = model_read(r2);
`else
        a = model_read(r1);
        b = model_read(r2);
        if (we) model_write(wr, wd);
        if (pend_wb) model_write(pend_dest, pend_val);
`endif
        ro  = ref_alu(aop, fc, a, b);
        res = use_c ? c_res : ro[DATA_W-1:0];
        v   = use_c ? c_ovf : ro[DATA_W];
        if (iv) begin
            exp_q.push_back({res, (res == '0), v});
            tag_q.push_back(tag);
        end
        pend_wb   = iv && wb;
        pend_dest = dst;
        pend_val  = ro[DATA_W-1:0];
        @(posedge clk);
        #1;
        ov_m = s1_m;
        s1_m = iv;
    endtask

    task automatic idle();
        drive_op(1'b0, 2'b00, 4'h0, '0, '0, 1'b0, '0, 1'b0, '0, '0, "", 1'b0, '0, 1'b0);
    endtask

    task automatic ext_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        drive_op(1'b0, 2'b00, 4'h0, '0, '0, 1'b0, '0, 1'b1, a, d, "", 1'b0, '0, 1'b0);
    endtask

    task automatic op_c(input logic [1:0] aop, input logic [3:0] fc,
                        input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2,
                        input logic wb, input logic [ADDR_W-1:0] dst, input string tag,
                        input logic [DATA_W-1:0] c_res, input logic c_ovf);
        drive_op(1'b1, aop, fc, r1, r2, wb, dst, 1'b0, '0, '0, tag, 1'b1, c_res, c_ovf);
    endtask

    task automatic read_c(input logic [ADDR_W-1:0] a, input string tag, input logic [DATA_W-1:0] exp);
        op_c(2'b11, 4'h0, '0, a, 1'b0, '0, tag, exp, 1'b0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("out_valid", 64'(out_valid), 64'(ov_m));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(1), 64'(0));
                end else begin
                    mon_e = exp_q.pop_front();
                    mon_t = tag_q.pop_front();
                    check(mon_t, 64'({ALUOut, Zero, ovf}), 64'(mon_e));
                    last_exp = mon_e;
                end
            end else begin
                check("hold", 64'({ALUOut, Zero, ovf}), 64'(last_exp));
            end
        end
    end

    initial begin
        for (int i = 0; i < NUM_REGS; i++) m_rf[i] = '0;
        #3;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_aluout", 64'(ALUOut), 64'(0));
        check("rst_zero", 64'(Zero), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        #13;
        rst_n = 1'b1;

        ext_write(5, 32'h5555_5555);
        ext_write(10, 32'hAAAA_AAAA);
        op_c(2'b10, 4'b0000, 5, 10, 1'b0, '0, "add_ff", 32'hFFFF_FFFF, 1'b0);
        op_c(2'b01, 4'h0, 5, 5, 1'b0, '0, "sub_zero", 32'h0, 1'b0);
        ext_write(2, 32'h7FFF_FFFF);
        ext_write(3, 32'h0000_0001);
        op_c(2'b00, 4'h0, 2, 3, 1'b0, '0, "add_ovf", 32'h8000_0000, 1'b1);
        op_c(2'b10, 4'b1010, 3, 2, 1'b0, '0, "slt", 32'h1, 1'b0);
        op_c(2'b10, 4'b1000, 3, 10, 1'b0, '0, "sll", 32'h0000_0400, 1'b0);
        op_c(2'b10, 4'b1111, 5, 10, 1'b0, '0, "undef_fc", 32'h0, 1'b0);

        ext_write(0, 32'h0000_1234);
        op_c(2'b11, 4'h0, '0, 5, 1'b1, 0, "wb_r0", 32'h5555_5555, 1'b0);
        idle();
        read_c(0, "r0_zero", 32'h0);

        ext_write(11, 32'h0000_BEEF);
        op_c(2'b11, 4'h0, '0, 11, 1'b1, 7, "beef_same", 32'h0000_BEEF, 1'b0);
        ext_write(7, 32'h0000_DEAD);
        idle();
        read_c(7, "same_addr_r7", 32'h0000_BEEF);
        op_c(2'b11, 4'h0, '0, 11, 1'b1, 8, "beef_diff", 32'h0000_BEEF, 1'b0);
        ext_write(7, 32'h0000_DEAD);
        idle();
        read_c(7, "diff_addr_r7", 32'h0000_DEAD);
        read_c(8, "diff_addr_r8", 32'h0000_BEEF);

        ext_write(1, 32'd10);
        ext_write(2, 32'd1);
        ext_write(3, 32'd2);
        idle();
        op_c(2'b00, 4'h0, 2, 3, 1'b1, 1, "dep_producer", 32'd3, 1'b0);
        op_c(2'b00, 4'h0, 1, 1, 1'b1, 4, "dep_consumer", DEP_RES, 1'b0);
        idle();
        idle();
        read_c(1, "dep_r1", 32'd3);
        read_c(4, "dep_r4", DEP_RES);

        idle();
        idle();
        ext_write(9, 32'h0000_0099);
        op_c(2'b11, 4'h0, '0, 9, 1'b1, 12, "pre_rst", 32'h0000_0099, 1'b0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        RegWrite = 1'b0;
        exp_q.delete();
        tag_q.delete();
        s1_m = 1'b0;
        ov_m = 1'b0;
        pend_wb = 1'b0;
        last_exp = '0;
        for (int i = 0; i < NUM_REGS; i++) m_rf[i] = '0;
        #3;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_aluout", 64'(ALUOut), 64'(0));
        #7;
        rst_n = 1'b1;
        check("postrst_out_valid", 64'(out_valid), 64'(0));
        check("postrst_aluout", 64'(ALUOut), 64'(0));
        for (int i = 0; i < NUM_REGS; i++) read_c(ADDR_W'(i), "rst_reg_zero", 32'h0);

        for (int n = 0; n < 300; n++) begin
            drive_op(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                     ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 7)),
                     ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : DATA_W'($urandom),
                     "rand", 1'b0, '0, 1'b0);
        end

        repeat (4) idle();
        check("drain", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_regfile_pipe.md
Name: alu_regfile_pipe

Overview:
- Parametrised successor to the single-cycle ALU plus register-file datapath.
- Contains a 2^ADDR_W x DATA_W register file, two read ports, an external write port and an ALU write-back port.
- Registered operand stage, then registered ALU result stage, giving a fixed 2-cycle issue-to-result latency.
- Sits in the core execute path; the decode unit drives it, the branch logic and memory stage consume its outputs.

Parameters:
DATA_W, 32, datapath and register width (≥8, power of 2)
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 is hardwired to zero and ignores writes

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  issue an operation this cycle
Read1  in  ADDR_W  operand A register address
Read2  in  ADDR_W  operand B register address
ALUOp  in  2  00 ADD, 01 SUB, 10 decode FuncCode, 11 pass B
FuncCode  in  4  function field, used when ALUOp=10
wb_en  in  1  write the ALU result back to dest_addr
dest_addr  in  ADDR_W  write-back destination
RegWrite  in  1  external write enable
WriteReg  in  ADDR_W  external write address
WriteData  in  DATA_W  external write data
out_valid  out  1  ALUOut/Zero/ovf valid this cycle
ALUOut  out  DATA_W  registered ALU result
Zero  out  1  registered: ALUOut == 0
ovf  out  1  registered signed overflow (ADD/SUB only)

Behaviour:
- Reset (async, rst_n=0): all registers = 0; stage-1 valid = 0; out_valid = 0; ALUOut = 0; Zero = 0; ovf = 0. Reset mid-operation drops every in-flight op; no write-back occurs.
- Edge N with in_valid=1: RF read at Read1/Read2; operands, decoded op, wb_en and dest_addr latch into stage 1; s1_valid=1.
- Edge N+1: ALU evaluates stage-1 operands. Result registers into ALUOut/Zero/ovf and out_valid=1. Latency is 2 edges. Throughput is one op per cycle with no stalls.
- out_valid is high for exactly one cycle per issued op. Zero, ovf and ALUOut hold their values when out_valid=0.
- Write-back: if the stage-1 op has wb_en=1, its result is written to RF[dest_addr] on the same edge ALUOut registers.
- External write: RegWrite=1 writes WriteData to RF[WriteReg] on the rising edge.
- Simultaneous external write and write-back:
  - Different addresses: both writes occur.
  - Same address: the ALU write-back wins.
- ZERO_REG=1: writes to address 0 from either port are discarded; reads of address 0 return 0.
- FuncCode decode (ALUOp=10):
  - 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0110 XOR, 0111 NOR
  - 1010 SLT (signed), 1011 SLTU
  - 1000 SLL, 1001 SRL; shift amount = B[log2(DATA_W)-1:0]
  - Other codes produce result 0 with ovf=0.
- Arithmetic:
  - Arithmetic is modulo 2^DATA_W.
  - SLT/SLTU produce 1 or 0, zero-extended to DATA_W.
  - ovf is set on signed overflow of ADD/SUB. It is 0 for every other op.
- Read-during-write (without the optional feature): a read on the same edge as a write to the same address returns the old value.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: read ports forward same-edge write data to stage 1.
  - The ALU write-back has priority over the external write, so the forwarded value is whichever write actually lands.
  - Back-to-back dependent ops (op N+1 reads op N's dest) therefore see the new value with no software gap.
- Undefined: no forwarding; the old value is read. A dependent op must issue ≥1 cycle after the producer's out_valid.

Test Plan:
- Write 0x55555555 to r5 and 0xAAAAAAAA to r10. Issue ALUOp=10, FuncCode=0000, Read1=5, Read2=10 -> out_valid 2 edges after issue, ALUOut=0xFFFFFFFF, Zero=0, ovf=0.
- Issue SUB r5-r5 (ALUOp=01) -> ALUOut=0, Zero=1. Then ADD 0x7FFFFFFF+0x00000001 -> ALUOut=0x80000000, ovf=1.
- Write 0x1234 to r0 via RegWrite, and issue an op with wb_en=1, dest=0 -> reading r0 returns 0.
- Same-edge external write (0xDEAD) and write-back (0xBEEF) to r7 -> r7=0xBEEF. Same edge with different addresses r7/r8 -> both written.
- Issue ADD r1=r2+r3 (r2=1, r3=2, wb_en) followed next cycle by ADD r4=r1+r1:
  - With RF_BYPASS_EN: second result = 6.
  - Without RF_BYPASS_EN: second result = 2×(old r1).
- Deassert rst_n for 10 ns between issue and result -> out_valid stays 0, no write-back, ALUOut=0, all registers read 0 afterwards.
